// File: rtl/wd_router_n.sv
// AXI W-channel router: beats follow AW order via a destination FIFO. Zero added latency on data/valid/ready.
// Backpressure: the master is stalled while the FIFO is empty or the selected slave is not ready.
module wd_router_n #(
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_BITS   = 32,
    parameter int STRB_BITS   = 4,
    parameter int LEN_BITS    = 4,
    parameter int OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SLAVES-1:0]           aw_push_sel,
    input  logic [LEN_BITS-1:0]             aw_push_len,
    output logic                            aw_full,
    output logic [$clog2(OUTSTANDING):0]    aw_pending,
    input  logic [DATA_BITS-1:0]            WDATA_M,
    input  logic [STRB_BITS-1:0]            WSTRB_M,
    input  logic                            WLAST_M,
    input  logic                            WVALID_M,
    output logic                            WREADY_M,
    output logic [NUM_SLAVES*DATA_BITS-1:0] WDATA_S,
    output logic [NUM_SLAVES*STRB_BITS-1:0] WSTRB_S,
    output logic [NUM_SLAVES-1:0]           WLAST_S,
    output logic [NUM_SLAVES-1:0]           WVALID_S,
    input  logic [NUM_SLAVES-1:0]           WREADY_S,
    output logic                            err_wlast,
    output logic                            err_push
);
    localparam int IDX_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int PTR_BITS = $clog2(OUTSTANDING);

    logic [IDX_BITS-1:0] q_idx [OUTSTANDING];
    logic [LEN_BITS-1:0] q_len [OUTSTANDING];
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    logic [PTR_BITS:0]   count;
    logic [LEN_BITS:0]   beat_cnt;
    logic [IDX_BITS-1:0] push_idx, head_idx;
    logic [LEN_BITS-1:0] head_len;
    logic                push_nz, push_onehot, head_vld, fire, pop, push, len_match;

    always_comb begin
        push_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (aw_push_sel[i]) push_idx = IDX_BITS'(i);
        end
    end

    assign push_nz     = |aw_push_sel;
    assign push_onehot = push_nz && ((aw_push_sel & (aw_push_sel - NUM_SLAVES'(1))) == '0);
    assign aw_full     = (count == (PTR_BITS+1)'(OUTSTANDING));
    assign aw_pending  = count;
    assign head_vld    = (count != '0);
    assign head_idx    = q_idx[rd_ptr];
    assign head_len    = q_len[rd_ptr];
    assign WREADY_M    = head_vld & WREADY_S[head_idx];
    assign fire        = WVALID_M & WREADY_M;
    assign pop         = fire & WLAST_M;
    // A pop in the same cycle frees the slot, so a push against a full FIFO is still taken.
    assign push        = push_onehot && (!aw_full || pop);
    assign len_match   = (beat_cnt == {1'b0, head_len});

    always_comb begin
        WDATA_S  = '0;
        WSTRB_S  = '1;
        WLAST_S  = '0;
        WVALID_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            WDATA_S[i*DATA_BITS +: DATA_BITS] = WDATA_M;
            WLAST_S[i] = WLAST_M;
            if (head_vld && head_idx == IDX_BITS'(i)) begin
                WVALID_S[i]                       = WVALID_M;
                WSTRB_S[i*STRB_BITS +: STRB_BITS] = WSTRB_M;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
            err_push  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            if (push && !pop)      count <= count + (PTR_BITS+1)'(1);
            else if (pop && !push) count <= count - (PTR_BITS+1)'(1);
            if (fire) begin
                if (WLAST_M) begin
                    beat_cnt <= '0;
                    if (!len_match) err_wlast <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + (LEN_BITS+1)'(1);
                    if (len_match) err_wlast <= 1'b1;
                end
            end
            if (push_nz && !push) err_push <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= push_idx;
            q_len[wr_ptr] <= aw_push_len;
        end
    end
endmodule

// File: tb/tb_wd_router_n.sv
// Directed bench for wd_router_n: routing order, stalls, overflow, WLAST checks and reset.
module tb_wd_router_n;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   aw_push_sel;
    logic [3:0]   aw_push_len;
    logic         aw_full;
    logic [2:0]   aw_pending;
    logic [31:0]  WDATA_M;
    logic [3:0]   WSTRB_M;
    logic         WLAST_M, WVALID_M, WREADY_M;
    logic [95:0]  WDATA_S;
    logic [11:0]  WSTRB_S;
    logic [2:0]   WLAST_S, WVALID_S, WREADY_S;
    logic         err_wlast, err_push;

    int checks = 0;
    int errors = 0;

    wd_router_n dut (
        .clk(clk), .rst(rst),
        .aw_push_sel(aw_push_sel), .aw_push_len(aw_push_len),
        .aw_full(aw_full), .aw_pending(aw_pending),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .err_wlast(err_wlast), .err_push(err_push)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; aw_push_sel = '0; WVALID_M = 1'b0; WLAST_M = 1'b0;
        tick;
        rst = 1'b1;
    endtask

    task automatic push(input logic [2:0] s, input logic [3:0] l);
        aw_push_sel = s; aw_push_len = l;
        tick;
        aw_push_sel = '0;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic last, input logic [2:0] exp_vs);
        WVALID_M = 1'b1; WDATA_M = d; WLAST_M = last;
        #1;
        chk({tag, "_vs"}, 128'(WVALID_S), 128'(exp_vs));
        chk({tag, "_rdy"}, 128'(WREADY_M), 128'(1'b1));
        tick;
        WVALID_M = 1'b0; WLAST_M = 1'b0;
    endtask

    initial begin
        rst = 1'b0; aw_push_sel = '0; aw_push_len = '0;
        WDATA_M = 32'hA5A5_0001; WSTRB_M = 4'h5; WLAST_M = 1'b1; WVALID_M = 1'b1;
        WREADY_S = 3'b111;
        tick; tick;
        rst = 1'b1;
        #1;
        chk("rst_pending", 128'(aw_pending), 128'(0));
        chk("rst_full", 128'(aw_full), 128'(0));
        chk("rst_wready", 128'(WREADY_M), 128'(0));
        chk("rst_wvalid", 128'(WVALID_S), 128'(0));
        chk("rst_errs", 128'({err_wlast, err_push}), 128'(0));
        chk("rst_strb", 128'(WSTRB_S), 128'(12'hFFF));
        chk("rst_data", 128'(WDATA_S), 128'(96'hA5A50001_A5A50001_A5A50001));
        chk("rst_last", 128'(WLAST_S), 128'(3'b111));
        WVALID_M = 1'b0; WLAST_M = 1'b0;

        // single burst, first with slave 1 backpressuring
        WREADY_S = 3'b101;
        push(3'b010, 4'd3);
        chk("t1_pending", 128'(aw_pending), 128'(1));
        WVALID_M = 1'b1; WDATA_M = 32'h0;
        #1;
        chk("t1_bp_vs", 128'(WVALID_S), 128'(3'b010));
        chk("t1_bp_rdy", 128'(WREADY_M), 128'(0));
        tick;
        chk("t1_bp_pending", 128'(aw_pending), 128'(1));
        WVALID_M = 1'b0; WREADY_S = 3'b111;
        for (int b = 0; b < 4; b++) beat("t1", 32'h100 + b, (b == 3), 3'b010);
        chk("t1_pending_end", 128'(aw_pending), 128'(0));
        chk("t1_errs", 128'({err_wlast, err_push}), 128'(0));

        // ordering across three queued bursts
        push(3'b001, 4'd0);
        push(3'b100, 4'd1);
        push(3'b010, 4'd0);
        chk("t2_pending3", 128'(aw_pending), 128'(3));
        beat("t2a", 32'h200, 1'b1, 3'b001);
        chk("t2_pending2", 128'(aw_pending), 128'(2));
        WVALID_M = 1'b1; WSTRB_M = 4'h3; WLAST_M = 1'b0;
        #1;
        chk("t2_strb", 128'(WSTRB_S), 128'(12'h3FF));
        chk("t2b_vs", 128'(WVALID_S), 128'(3'b100));
        tick;
        beat("t2c", 32'h202, 1'b1, 3'b100);
        beat("t2d", 32'h203, 1'b1, 3'b010);
        chk("t2_pending_end", 128'(aw_pending), 128'(0));
        chk("t2_errs", 128'({err_wlast, err_push}), 128'(0));

        // empty stall, then no same-cycle bypass
        WVALID_M = 1'b1; WLAST_M = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_stall_rdy", 128'(WREADY_M), 128'(0));
            chk("t3_stall_vs", 128'(WVALID_S), 128'(0));
            tick;
        end
        aw_push_sel = 3'b001; aw_push_len = 4'd0;
        #1;
        chk("t3_nobypass", 128'(WREADY_M), 128'(0));
        tick;
        aw_push_sel = '0;
        #1;
        chk("t3_rdy", 128'(WREADY_M), 128'(1));
        chk("t3_vs", 128'(WVALID_S), 128'(3'b001));
        tick;
        WVALID_M = 1'b0; WLAST_M = 1'b0;
        chk("t3_pending", 128'(aw_pending), 128'(0));

        // fill, overflow, push+pop while full, drain
        for (int k = 0; k < 4; k++) push(3'b001, 4'd0);
        chk("t4_full", 128'(aw_full), 128'(1));
        chk("t4_pending4", 128'(aw_pending), 128'(4));
        chk("t4_no_err_yet", 128'(err_push), 128'(0));
        push(3'b001, 4'd0);
        chk("t4_ovf_pending", 128'(aw_pending), 128'(4));
        chk("t4_ovf_err", 128'(err_push), 128'(1));
        aw_push_sel = 3'b010; aw_push_len = 4'd0; WVALID_M = 1'b1; WLAST_M = 1'b1;
        tick;
        aw_push_sel = '0; WVALID_M = 1'b0; WLAST_M = 1'b0;
        chk("t4_pushpop", 128'(aw_pending), 128'(4));
        for (int k = 0; k < 3; k++) beat("t4_drain", 32'h400 + k, 1'b1, 3'b001);
        beat("t4_wrap", 32'h4FF, 1'b1, 3'b010);
        chk("t4_empty", 128'(aw_pending), 128'(0));
        chk("t4_notfull", 128'(aw_full), 128'(0));

        // multi-hot push
        do_reset;
        chk("t4_err_cleared", 128'(err_push), 128'(0));
        push(3'b011, 4'd0);
        chk("t4_multi_err", 128'(err_push), 128'(1));
        chk("t4_multi_pending", 128'(aw_pending), 128'(0));

        // early WLAST
        do_reset;
        push(3'b100, 4'd2);
        beat("t5a", 32'h500, 1'b0, 3'b100);
        beat("t5b", 32'h501, 1'b1, 3'b100);
        chk("t5_early_err", 128'(err_wlast), 128'(1));
        chk("t5_early_pop", 128'(aw_pending), 128'(0));

        // missing WLAST
        do_reset;
        chk("t5_err_cleared", 128'(err_wlast), 128'(0));
        push(3'b010, 4'd1);
        beat("t5c", 32'h510, 1'b0, 3'b010);
        chk("t5_no_err", 128'(err_wlast), 128'(0));
        beat("t5d", 32'h511, 1'b0, 3'b010);
        chk("t5_late_err", 128'(err_wlast), 128'(1));
        beat("t5e", 32'h512, 1'b1, 3'b010);
        chk("t5_late_pop", 128'(aw_pending), 128'(0));

        // reset mid-burst
        do_reset;
        push(3'b001, 4'd3);
        beat("t6a", 32'h600, 1'b0, 3'b001);
        rst = 1'b0; WVALID_M = 1'b1;
        tick;
        rst = 1'b1;
        #1;
        chk("t6_pending", 128'(aw_pending), 128'(0));
        chk("t6_rdy", 128'(WREADY_M), 128'(0));
        chk("t6_vs", 128'(WVALID_S), 128'(0));
        chk("t6_errs", 128'({err_wlast, err_push}), 128'(0));
        WVALID_M = 1'b0;
        push(3'b100, 4'd0);
        beat("t6b", 32'h610, 1'b1, 3'b100);
        chk("t6_pending_end", 128'(aw_pending), 128'(0));
        chk("t6_wlast_ok", 128'(err_wlast), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
